if_id_inst_queue: RTL and testbench
===================================

// Module: if_id_inst_queue
// PURPOSE
//  Parametrised instruction queue between IF and ID; replaces the single-entry stall buffer in ID.
//  - Pairs each fetch PC with the inst_sram_rdata that returns one cycle after the fetch is issued.
//  - Buffers up to DEPTH {pc,inst} entries, so ID stalls never drop or re-read an SRAM word.
//  - Handles taken-branch flush with optional MIPS delay-slot retention.
// PARAMETERS
//  DEPTH       4   queue entries; min 2; full 1-inst/cycle throughput needs DEPTH>=3
//  PC_WD       32  PC width
//  INST_WD     32  instruction width
//  DELAY_SLOT  1   1: flush keeps the delay-slot instruction; 0: flush clears everything
// PORTS
//  clk              in   1          clock, all state on posedge
//  rst              in   1          asynchronous active-high reset
//  fetch_valid      in   1          IF issues an SRAM read for fetch_pc this cycle
//  fetch_pc         in   PC_WD      PC of the issued read
//  fetch_ready      out  1          queue can accept a fetch this cycle
//  inst_sram_rdata  in   INST_WD    SRAM data, valid one cycle after the accepted fetch
//  id_valid         out  1          head entry present
//  id_pc            out  PC_WD      head PC (0 when !id_valid)
//  id_inst          out  INST_WD    head instruction (0 when !id_valid)
//  id_ready         in   1          ID consumes the head this cycle (not stalled)
//  flush            in   1          head is a taken branch/jump and is consumed; redirect follows
//  slot_miss        out  1          1-cycle pulse: flush found no delay slot; IF must refetch it
//  count            out  clog2(DEPTH+1)  valid entries held
// BEHAVIOUR
//  - Reset: ptrs=0, count=0, pend_valid=0, slot_miss=0.
//    Outputs after reset: id_valid=0, id_pc=0, id_inst=0, fetch_ready=1.
//    Reset mid-operation discards all entries and the in-flight read immediately.
//  - fetch_ready = (count + pend_valid) < DEPTH.
//    Combinational from state only; must not depend on id_ready or flush.
//  - Accept: fetch_valid & fetch_ready & ~flush. Next edge: pend_valid<=1, pend_pc<=fetch_pc.
//    With no accept: pend_valid<=0.
//  - Write: while pend_valid=1, {pend_pc, inst_sram_rdata} is written at wr_ptr at the cycle end.
//    fetch_ready guarantees space, so a write never overflows.
//  - Read: id_valid = (count!=0). Head is combinational from the storage array, so ID latency is 0.
//    Pop when id_valid & id_ready.
//  - Latency: fetch accepted in cycle N -> visible at head in cycle N+2 (queue empty).
//  - Simultaneous push+pop: count unchanged, both ptrs advance.
//  - Pop with count==0: ignored. Ptrs wrap modulo DEPTH; DEPTH need not be a power of 2.
//  - Flush (edge at end of flush cycle); head is treated as popped:
//    - A fetch handshake in the flush cycle is dropped, and pend_valid<=0.
//    - DELAY_SLOT=0: count<=0, ptrs<=0, pending write dropped.
//    - DELAY_SLOT=1, count>=2: keep only entry head+1.
//      rd_ptr<=head+1, wr_ptr<=head+2, count<=1; pending write dropped.
//    - DELAY_SLOT=1, count==1, pend_valid=1: the pending write becomes the only entry, count<=1.
//    - DELAY_SLOT=1, count==1, pend_valid=0: count<=0; slot_miss<=1 for exactly one cycle.
//    - flush with count==0: illegal; block clears state and asserts nothing.
//  - flush is never combined into id_valid/id_inst: flush is derived from id_inst in ID, so gating would form a loop.
//  - id_pc/id_inst are forced to 0 when count==0, so ID decodes a NOP bubble.
// TESTING
//  1 Reset with rst high mid-burst of 3 fetches -> count=0, id_valid=0, fetch_ready=1 next cycle;
//    late rdata is ignored.
//  2 Streaming, DEPTH=4: fetch pc 0x0,0x4,0x8,... every cycle, id_ready=1 ->
//    id_pc 0x0 in cycle 2, then +4 every cycle, no bubbles.
//  3 Back-pressure: id_ready=0 for 8 cycles -> fetch_ready drops when count+pend_valid=4.
//    count holds at 4; on release, inst order is intact and none lost.
//  4 Flush, DELAY_SLOT=1: queue {0x10 beq, 0x14, 0x18}, flush -> next cycle count=1, id_pc=0x14;
//    0x18 and in-flight data are gone.
//  5 Flush, DELAY_SLOT=1: count=1 {0x20 j}, pend_pc=0x24 -> next cycle id_pc=0x24, id_inst=rdata of that cycle.
//    Same case with pend_valid=0 -> count=0, slot_miss pulses once.
//  6 DEPTH=2 variant, id_ready=1 streaming -> wraps correctly;
//    throughput 1 inst / 2 cycles, with fetch_ready alternating.

Source files
------------

// File: rtl/if_id_inst_queue_if.sv
// ---------------------------------------------------------------------------
// if_id_inst_queue_if
//   Bundles the IF-side fetch handshake, the SRAM return data, the ID-side
//   head/consume handshake and the flush/status signals of the IF->ID
//   instruction queue.
//   master : IF/ID pipeline side (issues fetches, consumes the head, flushes)
//   slave  : the queue itself
//   Params : PC_WD, INST_WD, CNT_WD (= clog2(DEPTH+1) of the attached queue)
// ---------------------------------------------------------------------------
interface if_id_inst_queue_if #(
  parameter int PC_WD   = 32,
  parameter int INST_WD = 32,
  parameter int CNT_WD  = 3
);
  logic               fetch_valid;
  logic [PC_WD-1:0]   fetch_pc;
  logic               fetch_ready;
  logic [INST_WD-1:0] inst_sram_rdata;
  logic               id_valid;
  logic [PC_WD-1:0]   id_pc;
  logic [INST_WD-1:0] id_inst;
  logic               id_ready;
  logic               flush;
  logic               slot_miss;
  logic [CNT_WD-1:0]  count;

  modport master (
    output fetch_valid, fetch_pc, inst_sram_rdata, id_ready, flush,
    input  fetch_ready, id_valid, id_pc, id_inst, slot_miss, count
  );

  modport slave (
    input  fetch_valid, fetch_pc, inst_sram_rdata, id_ready, flush,
    output fetch_ready, id_valid, id_pc, id_inst, slot_miss, count
  );
endinterface

// File: rtl/if_id_inst_queue.sv
// ---------------------------------------------------------------------------
// if_id_inst_queue
//   Instruction queue between IF and ID. Each accepted fetch PC is held as
//   "pending" for one cycle and paired with the SRAM word that returns in that
//   cycle; the pair is then stored in a DEPTH-entry circular buffer whose head
//   is presented combinationally to ID. A taken branch (flush) discards the
//   queue, optionally keeping the delay-slot instruction.
// Ports
//   clk, rst  : clock, asynchronous active-high reset
//   q (slave) : fetch_valid/fetch_pc/fetch_ready  fetch handshake
//               inst_sram_rdata                   SRAM data, 1 cycle after fetch
//               id_valid/id_pc/id_inst/id_ready   head handshake to ID
//               flush                             head is a taken branch
//               slot_miss                         flush found no delay slot
//               count                             valid entries held
// ---------------------------------------------------------------------------
module if_id_inst_queue #(
  parameter int DEPTH      = 4,
  parameter int PC_WD      = 32,
  parameter int INST_WD    = 32,
  parameter int DELAY_SLOT = 1
) (
  input logic                clk,
  input logic                rst,
  if_id_inst_queue_if.slave  q
);
  localparam int PTR_WD = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_WD = $clog2(DEPTH + 1);
  localparam logic [CNT_WD:0] DEPTH_W = (CNT_WD + 1)'(DEPTH);

  typedef struct packed {
    logic [PC_WD-1:0]   pc;
    logic [INST_WD-1:0] inst;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_WD-1:0]  rd_ptr, wr_ptr;
  logic [CNT_WD-1:0]  count_r;
  logic               pend_valid;
  logic [PC_WD-1:0]   pend_pc;
  logic               slot_miss_r;

  logic accept, pop, mem_we, has_head;

  // Wrap explicitly so non power-of-two depths work.
  function automatic logic [PTR_WD-1:0] ptr_inc(input logic [PTR_WD-1:0] p);
    return (p == PTR_WD'(DEPTH - 1)) ? '0 : p + PTR_WD'(1);
  endfunction

  // Reserve a slot for the in-flight read too, so a write never overflows.
  assign q.fetch_ready = ({1'b0, count_r} + {{CNT_WD{1'b0}}, pend_valid}) < DEPTH_W;

  assign has_head = (count_r != '0);
  assign accept   = q.fetch_valid & q.fetch_ready & ~q.flush;
  assign pop      = has_head & q.id_ready;

  // On flush the pending word is only kept when it is the delay slot, i.e.
  // the flushed branch was the sole entry. It lands at wr_ptr either way.
  assign mem_we = pend_valid & (~q.flush | ((DELAY_SLOT != 0) && (count_r == CNT_WD'(1))));

  always_ff @(posedge clk)
    if (mem_we) mem[wr_ptr] <= {pend_pc, q.inst_sram_rdata};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count_r     <= '0;
      pend_valid  <= 1'b0;
      pend_pc     <= '0;
      slot_miss_r <= 1'b0;
    end else begin
      slot_miss_r <= 1'b0;
      pend_valid  <= accept;
      if (accept) pend_pc <= q.fetch_pc;

      if (q.flush) begin
        // Head (the branch) is consumed in every flush case.
        if ((DELAY_SLOT == 0) || (count_r == '0)) begin
          rd_ptr  <= '0;
          wr_ptr  <= '0;
          count_r <= '0;
        end else if (count_r >= CNT_WD'(2)) begin
          rd_ptr  <= ptr_inc(rd_ptr);
          wr_ptr  <= ptr_inc(ptr_inc(rd_ptr));
          count_r <= CNT_WD'(1);
        end else if (pend_valid) begin
          rd_ptr  <= wr_ptr;
          wr_ptr  <= ptr_inc(wr_ptr);
          count_r <= CNT_WD'(1);
        end else begin
          rd_ptr      <= ptr_inc(rd_ptr);
          count_r     <= '0;
          slot_miss_r <= 1'b1;
        end
      end else begin
        if (pend_valid) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)        rd_ptr <= ptr_inc(rd_ptr);
        count_r <= count_r + CNT_WD'(pend_valid) - CNT_WD'(pop);
      end
    end
  end

  // Head is never gated by flush: flush is decoded from id_inst in ID.
  assign q.id_valid  = has_head;
  assign q.id_pc     = has_head ? mem[rd_ptr].pc   : '0;
  assign q.id_inst   = has_head ? mem[rd_ptr].inst : '0;
  assign q.slot_miss = slot_miss_r;
  assign q.count     = count_r;
endmodule

// File: tb/tb_if_id_inst_queue.sv
module tb_if_id_inst_queue;
  logic clk, rst;
  int errors = 0;
  int checks = 0;

  if_id_inst_queue_if #(.PC_WD(32), .INST_WD(32), .CNT_WD(3)) q  ();
  if_id_inst_queue_if #(.PC_WD(32), .INST_WD(32), .CNT_WD(2)) q2 ();

  if_id_inst_queue #(.DEPTH(4), .PC_WD(32), .INST_WD(32), .DELAY_SLOT(1)) dut (
    .clk(clk), .rst(rst), .q(q));
  if_id_inst_queue #(.DEPTH(2), .PC_WD(32), .INST_WD(32), .DELAY_SLOT(1)) dut2 (
    .clk(clk), .rst(rst), .q(q2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        sb[$];
  logic        pend;
  logic [31:0] pend_pc;
  logic [31:0] next_pc;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc * 32'd3 + 32'hC0DE_0000;
  endfunction

  // One cycle on the DEPTH=4 queue: drive, sample at negedge, compare the
  // head against the scoreboard, advance the model, then check slot_miss.
  task automatic step(input bit fv, input bit rdy, input bit fl,
                      output bit v_o, output logic [31:0] pc_o, output logic [31:0] inst_o,
                      output int cnt_o, output bit fr_o, output bit slot_o);
    bit   exp_fr, acc, exp_slot;
    int   n;
    ent_t e;
    q.fetch_valid     = fv;
    q.fetch_pc        = next_pc;
    q.id_ready        = rdy;
    q.flush           = fl;
    q.inst_sram_rdata = pend ? inst_of(pend_pc) : 32'hBAD0_BAD0;
    @(negedge clk);
    n      = sb.size();
    exp_fr = (n + int'(pend)) < 4;
    v_o = q.id_valid; pc_o = q.id_pc; inst_o = q.id_inst; cnt_o = int'(q.count); fr_o = q.fetch_ready;
    checks++;
    if (q.count !== 3'(n)) begin errors++; $display("FAIL count: got %0d want %0d", q.count, n); end
    checks++;
    if (q.fetch_ready !== exp_fr) begin errors++; $display("FAIL fetch_ready: got %b want %b", q.fetch_ready, exp_fr); end
    checks++;
    if (q.id_valid !== (n != 0)) begin errors++; $display("FAIL id_valid: got %b want %b", q.id_valid, n != 0); end
    checks++;
    if (n != 0) begin
      if (q.id_pc !== sb[0].pc || q.id_inst !== sb[0].inst) begin
        errors++;
        $display("FAIL head: got pc=%h inst=%h want pc=%h inst=%h", q.id_pc, q.id_inst, sb[0].pc, sb[0].inst);
      end
    end else if (q.id_pc !== 32'h0 || q.id_inst !== 32'h0) begin
      errors++;
      $display("FAIL bubble: got pc=%h inst=%h want 0", q.id_pc, q.id_inst);
    end
    acc      = fv & exp_fr & ~fl;
    exp_slot = 1'b0;
    if (fl) begin
      if (n >= 2) begin e = sb[1]; sb.delete(); sb.push_back(e); end
      else if (n == 1 && pend) begin sb.delete(); sb.push_back('{pend_pc, inst_of(pend_pc)}); end
      else if (n == 1) begin sb.delete(); exp_slot = 1'b1; end
      else sb.delete();
    end else begin
      if (n != 0 && rdy) void'(sb.pop_front());
      if (pend) sb.push_back('{pend_pc, inst_of(pend_pc)});
    end
    pend = acc;
    if (acc) begin pend_pc = next_pc; next_pc += 32'd4; end
    @(posedge clk); #1;
    slot_o = q.slot_miss;
    checks++;
    if (q.slot_miss !== exp_slot) begin errors++; $display("FAIL slot_miss: got %b want %b", q.slot_miss, exp_slot); end
  endtask

  task automatic drain(output int popped);
    bit v; logic [31:0] p, i; int c; bit f, s;
    popped = 0;
    for (int k = 0; k < 12 && (sb.size() != 0 || pend); k++) begin
      step(0, 1, 0, v, p, i, c, f, s);
      if (v) popped++;
    end
    checks++;
    if (sb.size() != 0 || pend) begin errors++; $display("FAIL drain: %0d entries left, want 0", sb.size()); end
  endtask

  task automatic test_reset();
    bit v; logic [31:0] p, i; int c; bit f, s;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete(); pend = 1'b0; next_pc = 32'h0;
    checks++;
    if (q.count !== 3'd0 || q.id_valid !== 1'b0 || q.id_pc !== 32'h0 || q.id_inst !== 32'h0 ||
        q.fetch_ready !== 1'b1 || q.slot_miss !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got cnt=%0d v=%b pc=%h inst=%h fr=%b sm=%b want 0 0 0 0 1 0",
               q.count, q.id_valid, q.id_pc, q.id_inst, q.fetch_ready, q.slot_miss);
    end
    repeat (3) step(1, 0, 0, v, p, i, c, f, s);
    rst = 1'b1;
    q.inst_sram_rdata = inst_of(pend_pc);
    #1;
    checks++;
    if (q.count !== 3'd0 || q.id_valid !== 1'b0 || q.fetch_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got cnt=%0d v=%b fr=%b want 0 0 1", q.count, q.id_valid, q.fetch_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
    sb.delete(); pend = 1'b0;
    repeat (2) begin
      step(0, 0, 0, v, p, i, c, f, s);
      checks++;
      if (c != 0 || v) begin errors++; $display("FAIL late_rdata: got cnt=%0d v=%b want 0 0", c, v); end
    end
  endtask

  task automatic test_stream();
    bit v; logic [31:0] p, i; int c, d; bit f, s;
    next_pc = 32'h0;
    for (int k = 0; k < 12; k++) begin
      step(1, 1, 0, v, p, i, c, f, s);
      checks++;
      if (k < 2 && v) begin errors++; $display("FAIL stream_lat: cycle %0d got v=1 want 0", k); end
      if (k >= 2 && (!v || p !== 32'(4 * (k - 2)))) begin
        errors++;
        $display("FAIL stream: cycle %0d got v=%b pc=%h want v=1 pc=%h", k, v, p, 32'(4 * (k - 2)));
      end
    end
    drain(d);
  endtask

  task automatic test_backpressure();
    bit v; logic [31:0] p, i; int c, d; bit f, s;
    next_pc = 32'h200;
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 0, v, p, i, c, f, s);
      checks++;
      if (f !== (k < 4)) begin errors++; $display("FAIL bp_ready: cycle %0d got %b want %b", k, f, k < 4); end
    end
    checks++;
    if (c != 4) begin errors++; $display("FAIL bp_count: got %0d want 4", c); end
    drain(d);
    checks++;
    if (d != 4) begin errors++; $display("FAIL bp_release: got %0d pops want 4", d); end
  endtask

  task automatic test_flush_slot();
    bit v; logic [31:0] p, i; int c, d; bit f, s;
    next_pc = 32'h10;
    repeat (4) step(1, 0, 0, v, p, i, c, f, s);
    step(1, 0, 1, v, p, i, c, f, s);
    checks++;
    if (c != 3 || p !== 32'h10) begin errors++; $display("FAIL flush_pre: got cnt=%0d pc=%h want 3 00000010", c, p); end
    step(0, 0, 0, v, p, i, c, f, s);
    checks++;
    if (c != 1 || p !== 32'h14) begin errors++; $display("FAIL flush_keep: got cnt=%0d pc=%h want 1 00000014", c, p); end
    drain(d);
    checks++;
    if (d != 1) begin errors++; $display("FAIL flush_gone: got %0d pops want 1", d); end
  endtask

  task automatic test_flush_pending();
    bit v; logic [31:0] p, i; int c, d; bit f, s;
    next_pc = 32'h20;
    repeat (2) step(1, 0, 0, v, p, i, c, f, s);
    step(0, 0, 1, v, p, i, c, f, s);
    step(0, 0, 0, v, p, i, c, f, s);
    checks++;
    if (c != 1 || p !== 32'h24 || i !== inst_of(32'h24)) begin
      errors++;
      $display("FAIL flush_pend: got cnt=%0d pc=%h inst=%h want 1 00000024 %h", c, p, i, inst_of(32'h24));
    end
    drain(d);
    next_pc = 32'h40;
    step(1, 0, 0, v, p, i, c, f, s);
    step(0, 0, 0, v, p, i, c, f, s);
    step(0, 0, 1, v, p, i, c, f, s);
    checks++;
    if (s !== 1'b1) begin errors++; $display("FAIL slot_pulse: got %b want 1", s); end
    step(0, 0, 0, v, p, i, c, f, s);
    checks++;
    if (s !== 1'b0 || c != 0) begin errors++; $display("FAIL slot_once: got sm=%b cnt=%0d want 0 0", s, c); end
  endtask

  task automatic test_depth2();
    ent_t        sb2[$];
    bit          pend2, exp_fr;
    logic [31:0] pc2, ppc2;
    int          delivered, stalls;
    pend2 = 1'b0; pc2 = 32'h100; ppc2 = 32'h0; delivered = 0; stalls = 0;
    for (int k = 0; k < 20; k++) begin
      q2.fetch_valid     = 1'b1;
      q2.fetch_pc        = pc2;
      q2.id_ready        = 1'b1;
      q2.flush           = 1'b0;
      q2.inst_sram_rdata = pend2 ? inst_of(ppc2) : 32'hBAD0_BAD0;
      @(negedge clk);
      exp_fr = (sb2.size() + int'(pend2)) < 2;
      checks++;
      if (q2.fetch_ready !== exp_fr || q2.count !== 2'(sb2.size())) begin
        errors++;
        $display("FAIL d2_state: cycle %0d got fr=%b cnt=%0d want %b %0d", k, q2.fetch_ready, q2.count, exp_fr, sb2.size());
      end
      checks++;
      if (q2.id_valid !== (sb2.size() != 0)) begin
        errors++; $display("FAIL d2_valid: cycle %0d got %b want %b", k, q2.id_valid, sb2.size() != 0);
      end
      if (sb2.size() != 0) begin
        checks++;
        if (q2.id_pc !== sb2[0].pc || q2.id_inst !== sb2[0].inst) begin
          errors++;
          $display("FAIL d2_head: got pc=%h inst=%h want pc=%h inst=%h", q2.id_pc, q2.id_inst, sb2[0].pc, sb2[0].inst);
        end
        void'(sb2.pop_front());
        delivered++;
      end
      if (!exp_fr) stalls++;
      if (pend2) sb2.push_back('{ppc2, inst_of(ppc2)});
      pend2 = exp_fr;
      if (exp_fr) begin ppc2 = pc2; pc2 += 32'd4; end
      @(posedge clk); #1;
    end
    q2.fetch_valid = 1'b0;
    checks++;
    if (delivered < 9) begin errors++; $display("FAIL d2_rate: got %0d insts in 20 cycles want >= 9", delivered); end
    checks++;
    if (stalls < 3) begin errors++; $display("FAIL d2_ready: got %0d not-ready cycles want >= 3", stalls); end
  endtask

  initial begin
    q.fetch_valid = 1'b0; q.fetch_pc = '0; q.id_ready = 1'b0; q.flush = 1'b0; q.inst_sram_rdata = '0;
    q2.fetch_valid = 1'b0; q2.fetch_pc = '0; q2.id_ready = 1'b0; q2.flush = 1'b0; q2.inst_sram_rdata = '0;
    pend = 1'b0; pend_pc = '0; next_pc = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_slot();
    test_flush_pending();
    test_depth2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
